// File: rtl/ise_pkg.sv
// Shared types and width helpers for the image sort engine.
//   color_e   dominant-colour class, also the primary sort key (R < G < B)
//   state_e   insertion-sort / drain FSM states
//   *_width   derived widths from the engine parameters
package ise_pkg;

   typedef enum logic [1:0] {
      COL_R = 2'd0,
      COL_G = 2'd1,
      COL_B = 2'd2
   } color_e;

   typedef enum logic [2:0] {
      ST_ACCEPT,
      ST_CMP_CLASS,
      ST_MUL,
      ST_CMP_AVG,
      ST_SWAP,
      ST_DRAIN
   } state_e;

   function automatic int idx_width(input int n_img);
      return (n_img > 1) ? $clog2(n_img) : 1;
   endfunction

   // One extra bit so a full image of one class (PIX_PER_IMG) fits.
   function automatic int cnt_width(input int pix);
      return $clog2(pix) + 1;
   endfunction

   // Worst case is every pixel at full scale in one class.
   function automatic int mag_width(input int cw, input int pix);
      return cw + $clog2(pix);
   endfunction

endpackage

// File: rtl/ise_seq_mul.sv
// Sequential shift-add multiplier, one multiplier bit per cycle.
//   clk, reset_n  clock, async active-low reset
//   start         load operands (one-cycle pulse)
//   a, b          multiplicand (A_W), multiplier (B_W)
//   done          high during the last of the B_W iterations
//   product       a*b, valid from the cycle after done until the next start
module ise_seq_mul #(
   parameter int A_W = 15,
   parameter int B_W = 22
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [A_W-1:0]     a,
   input  logic [B_W-1:0]     b,
   output logic               done,
   output logic [A_W+B_W-1:0] product
);

   localparam int P_W  = A_W + B_W;
   localparam int IT_W = $clog2(B_W + 1);

   logic            run;
   logic [IT_W-1:0] iter;
   logic [P_W-1:0]  a_sh;
   logic [P_W-1:0]  acc;
   logic [B_W-1:0]  b_sh;

   // Combinational done lets the caller leave its wait state on the same
   // edge that retires the final partial product.
   assign done    = run && (iter == IT_W'(B_W - 1));
   assign product = acc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run  <= 1'b0;
         iter <= '0;
         a_sh <= '0;
         b_sh <= '0;
         acc  <= '0;
      end else if (start) begin
         run  <= 1'b1;
         iter <= '0;
         a_sh <= P_W'(a);
         b_sh <= b;
         acc  <= '0;
      end else if (run) begin
         if (b_sh[0]) acc <= acc + a_sh;
         a_sh <= a_sh << 1;
         b_sh <= b_sh >> 1;
         iter <= iter + IT_W'(1);
         if (done) run <= 1'b0;
      end
   end

endmodule

// File: rtl/image_sort_engine.sv
// Streams N_IMG images, classifies each by dominant colour, insertion-sorts
// the records and drains the sorted list through a ready/valid port.
//   clk, reset_n                 clock, async active-low reset
//   in_valid, busy               pixel handshake (accept = in_valid & ~busy)
//   image_in_index, pixel_in     image tag (first pixel), {R,G,B} pixel
//   descend                      average order within a class, held per batch
//   out_valid, out_ready         record handshake
//   color_index, image_out_index, out_last   sorted record
//
// state        | meaning
// ACCEPT       | idle; loads pending record at list tail
// CMP_CLASS    | compare class of entries i-1 and i
// MUL          | cross products of mag/cnt running
// CMP_AVG      | compare averages via cross products
// SWAP         | swap entries i-1 and i, step i down
// DRAIN        | present sorted list, one record per handshake
module image_sort_engine
   import ise_pkg::*;
#(
   parameter int N_IMG       = 32,
   parameter int PIX_PER_IMG = 16384,
   parameter int CW          = 8,
   parameter int IDX_W       = idx_width(N_IMG),
   parameter int CNT_W       = cnt_width(PIX_PER_IMG),
   parameter int MAG_W       = mag_width(CW, PIX_PER_IMG)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             busy,
   input  logic [IDX_W-1:0] image_in_index,
   input  logic [3*CW-1:0]  pixel_in,
   input  logic             descend,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       color_index,
   output logic [IDX_W-1:0] image_out_index,
   output logic             out_last
);

   localparam int PIX_W  = $clog2(PIX_PER_IMG);
   localparam int TAIL_W = IDX_W + 1;
   localparam int PROD_W = CNT_W + MAG_W;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      color_e           color;
      logic [CNT_W-1:0] cnt;
      logic [MAG_W-1:0] mag;
   } rec_t;

   logic [CW-1:0] ch_r, ch_g, ch_b;
   assign ch_r = pixel_in[3*CW-1:2*CW];
   assign ch_g = pixel_in[2*CW-1:CW];
   assign ch_b = pixel_in[CW-1:0];

   state_e                  state, state_nxt;
   logic [PIX_W-1:0]        pix_cnt;
   logic [IDX_W-1:0]        cur_idx;
   logic [2:0][CNT_W-1:0]   acc_cnt, nxt_cnt;
   logic [2:0][MAG_W-1:0]   acc_mag, nxt_mag;
   color_e                  pix_col;
   logic [CW-1:0]           pix_val;
   rec_t                    done_rec, pend_rec;
   logic                    pend_valid;
   rec_t                    list [N_IMG];
   logic [TAIL_W-1:0]       tail;
   logic [IDX_W-1:0]        i_ptr, im1, rd_ptr;
   logic                    desc_q;
   rec_t                    ent_lo, ent_hi;
   logic                    first_pix, accept, complete;
   logic                    load, swap, ins_done, mul_start, drain_hs, drain_last;
   logic                    mul_done_a, mul_done_b, mul_done, out_of_order;
   logic [PROD_W-1:0]       prod_a, prod_b;

   // ---------------- pixel accumulation ----------------
   assign first_pix = (pix_cnt == '0);
   assign accept    = in_valid & ~busy;
   assign complete  = accept & (pix_cnt == PIX_W'(PIX_PER_IMG - 1));

   always_comb begin
      pix_col = COL_B;
      pix_val = ch_b;
      if (ch_r >= ch_g && ch_r >= ch_b) begin
         pix_col = COL_R;
         pix_val = ch_r;
      end else if (ch_g >= ch_b) begin
         pix_col = COL_G;
         pix_val = ch_g;
      end
   end

   // Accumulators as they will be after this pixel; also feeds the record
   // built on the last pixel, so completion needs no extra cycle.
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         nxt_cnt[k] = first_pix ? '0 : acc_cnt[k];
         nxt_mag[k] = first_pix ? '0 : acc_mag[k];
         if (int'(pix_col) == k) begin
            nxt_cnt[k] = nxt_cnt[k] + CNT_W'(1);
            nxt_mag[k] = nxt_mag[k] + MAG_W'(pix_val);
         end
      end
   end

   always_comb begin
      done_rec.idx   = first_pix ? image_in_index : cur_idx;
      done_rec.color = COL_B;
      done_rec.cnt   = nxt_cnt[2];
      done_rec.mag   = nxt_mag[2];
      if (nxt_cnt[0] >= nxt_cnt[1] && nxt_cnt[0] >= nxt_cnt[2]) begin
         done_rec.color = COL_R;
         done_rec.cnt   = nxt_cnt[0];
         done_rec.mag   = nxt_mag[0];
      end else if (nxt_cnt[1] >= nxt_cnt[2]) begin
         done_rec.color = COL_G;
         done_rec.cnt   = nxt_cnt[1];
         done_rec.mag   = nxt_mag[1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_cnt <= '0;
         cur_idx <= '0;
         acc_cnt <= '0;
         acc_mag <= '0;
      end else if (accept) begin
         pix_cnt <= pix_cnt + PIX_W'(1);
         acc_cnt <= nxt_cnt;
         acc_mag <= nxt_mag;
         if (first_pix) cur_idx <= image_in_index;
      end
   end

   // Stall only when a second finished image would have nowhere to go.
   assign busy = (state == ST_DRAIN) |
                 (pend_valid & (state != ST_ACCEPT) & (pix_cnt == PIX_W'(PIX_PER_IMG - 1)));

   // ---------------- sorter ----------------
   assign im1    = i_ptr - IDX_W'(1);
   assign ent_lo = list[im1];
   assign ent_hi = list[i_ptr];

   // prod_a ~ avg(i-1), prod_b ~ avg(i) after cross-multiplying by the counts.
   ise_seq_mul #(.A_W(CNT_W), .B_W(MAG_W)) u_mul_a (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (mul_start),
      .a       (ent_hi.cnt),
      .b       (ent_lo.mag),
      .done    (mul_done_a),
      .product (prod_a)
   );

   ise_seq_mul #(.A_W(CNT_W), .B_W(MAG_W)) u_mul_b (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (mul_start),
      .a       (ent_lo.cnt),
      .b       (ent_hi.mag),
      .done    (mul_done_b),
      .product (prod_b)
   );

   assign mul_done     = mul_done_a & mul_done_b;
   // Equal averages never swap, which keeps equal keys in arrival order.
   assign out_of_order = desc_q ? (prod_a < prod_b) : (prod_a > prod_b);
   assign drain_last   = (rd_ptr == IDX_W'(N_IMG - 1));

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      swap      = 1'b0;
      ins_done  = 1'b0;
      mul_start = 1'b0;
      drain_hs  = 1'b0;
      case (state)
         ST_ACCEPT: begin
            if (pend_valid) begin
               load      = 1'b1;
               state_nxt = ST_CMP_CLASS;
            end
         end
         ST_CMP_CLASS: begin
            if (i_ptr == '0) begin
               ins_done = 1'b1;
            end else if (ent_lo.color > ent_hi.color) begin
               state_nxt = ST_SWAP;
            end else if (ent_lo.color == ent_hi.color) begin
               mul_start = 1'b1;
               state_nxt = ST_MUL;
            end else begin
               ins_done = 1'b1;
            end
         end
         ST_MUL: begin
            if (mul_done) state_nxt = ST_CMP_AVG;
         end
         ST_CMP_AVG: begin
            if (out_of_order) state_nxt = ST_SWAP;
            else              ins_done  = 1'b1;
         end
         ST_SWAP: begin
            swap = 1'b1;
            if (im1 == '0) ins_done  = 1'b1;
            else           state_nxt = ST_CMP_CLASS;
         end
         ST_DRAIN: begin
            drain_hs = out_ready;
            if (out_ready && drain_last) state_nxt = ST_ACCEPT;
         end
         default: state_nxt = ST_ACCEPT;
      endcase
      if (ins_done) state_nxt = (tail == TAIL_W'(N_IMG)) ? ST_DRAIN : ST_ACCEPT;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_ACCEPT;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < N_IMG; k++) list[k] <= '0;
         tail       <= '0;
         i_ptr      <= '0;
         rd_ptr     <= '0;
         desc_q     <= 1'b0;
         pend_valid <= 1'b0;
         pend_rec   <= '0;
      end else begin
         // Order mode tracks the input only while the list is empty.
         if (state == ST_ACCEPT && tail == '0) desc_q <= descend;
         if (complete) begin
            pend_rec   <= done_rec;
            pend_valid <= 1'b1;
         end else if (load) begin
            pend_valid <= 1'b0;
         end
         if (load) begin
            list[tail[IDX_W-1:0]] <= pend_rec;
            i_ptr                 <= tail[IDX_W-1:0];
            tail                  <= tail + TAIL_W'(1);
         end
         if (swap) begin
            list[im1]   <= list[i_ptr];
            list[i_ptr] <= list[im1];
            i_ptr       <= im1;
         end
         if (drain_hs) begin
            if (drain_last) begin
               rd_ptr <= '0;
               tail   <= '0;
            end else begin
               rd_ptr <= rd_ptr + IDX_W'(1);
            end
         end
      end
   end

   // ---------------- output ----------------
   assign out_valid       = (state == ST_DRAIN);
   assign color_index     = out_valid ? list[rd_ptr].color : 2'd0;
   assign image_out_index = out_valid ? list[rd_ptr].idx   : '0;
   assign out_last        = out_valid & drain_last;

endmodule

// File: tb/tb_image_sort_engine.sv
`timescale 1ns/1ps
module tb_image_sort_engine;

   localparam int N   = 4;
   localparam int PIX = 16;
   localparam int CW  = 8;
   localparam int IW  = 2;
   localparam logic [1:0] CR = 2'd0, CG = 2'd1, CB = 2'd2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          descend = 1'b0;
   logic          out_ready = 1'b1;
   logic [IW-1:0] image_in_index = '0;
   logic [3*CW-1:0] pixel_in = '0;
   logic          busy, out_valid, out_last;
   logic [1:0]    color_index;
   logic [IW-1:0] image_out_index;

   int   checks = 0;
   int   errors = 0;
   logic toggle_mode = 1'b0;
   logic [3:0] rdy_pat = 4'b1001;
   int   rk = 0;

   typedef struct packed {
      logic [1:0]    col;
      logic [IW-1:0] idx;
      logic          last;
   } exp_t;
   exp_t exp_q[$];

   image_sort_engine #(.N_IMG(N), .PIX_PER_IMG(PIX), .CW(CW)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .in_valid        (in_valid),
      .busy            (busy),
      .image_in_index  (image_in_index),
      .pixel_in        (pixel_in),
      .descend         (descend),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .color_index     (color_index),
      .image_out_index (image_out_index),
      .out_last        (out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic logic [23:0] px(input int r, input int g, input int b);
      return {8'(r), 8'(g), 8'(b)};
   endfunction

   task automatic push_exp(input logic [1:0] col, input logic [IW-1:0] idx, input logic last);
      exp_t e;
      e.col  = col;
      e.idx  = idx;
      e.last = last;
      exp_q.push_back(e);
   endtask

   // Record monitor: the front of the queue must be on the port whenever
   // out_valid is high (so stalled records are re-checked every cycle);
   // it is retired only on a handshake.
   always @(negedge clk) begin
      if (reset_n && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_record: actual idx=%0d col=%0d, required no record",
                     image_out_index, color_index);
         end else begin
            chk("rec_color", 32'(color_index), 32'(exp_q[0].col));
            chk("rec_idx", 32'(image_out_index), 32'(exp_q[0].idx));
            chk("rec_last", 32'(out_last), 32'(exp_q[0].last));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (toggle_mode) begin
         out_ready = rdy_pat[rk];
         rk = (rk + 1) % 4;
      end else begin
         out_ready = 1'b1;
      end
   end

   // Called on a negedge; returns on the negedge after the pixel was taken.
   task automatic send_pixel(input logic [IW-1:0] tag, input logic [23:0] p);
      int guard;
      guard = 0;
      in_valid       = 1'b1;
      image_in_index = tag;
      pixel_in       = p;
      while (busy === 1'b1 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 1000) begin
         errors++;
         $display("FAIL busy_timeout: busy=1 for %0d cycles, required release", guard);
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $fatal(1, "busy never released");
      end
      @(negedge clk);
   endtask

   task automatic send_image(input logic [IW-1:0] tag, input logic [23:0] pa,
                             input int na, input logic [23:0] pb);
      for (int p = 0; p < PIX; p++) send_pixel(tag, (p < na) ? pa : pb);
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      in_valid = 1'b0;
      while (exp_q.size() != 0 && g < 3000) begin
         @(negedge clk);
         g++;
      end
      chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
   endtask

   task automatic reset_checks();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_color", 32'(color_index), 32'd0);
      chk("rst_idx", 32'(image_out_index), 32'd0);
   endtask

   task automatic batch_basic();
      send_image(0, px(10, 0, 0), PIX, px(10, 0, 0));
      send_image(1, px(0, 0, 200), PIX, px(0, 0, 200));
      send_image(2, px(0, 120, 0), PIX, px(0, 120, 0));
      send_image(3, px(50, 0, 0), PIX, px(50, 0, 0));
   endtask

   initial begin
      #1;
      reset_checks();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Mixed classes, ascending averages within R.
      descend = 1'b0;
      push_exp(CR, 0, 0); push_exp(CR, 3, 0); push_exp(CG, 2, 0); push_exp(CB, 1, 1);
      batch_basic();
      wait_drain();

      // Same images descending, with a stalling sink.
      descend     = 1'b1;
      toggle_mode = 1'b1;
      push_exp(CR, 3, 0); push_exp(CR, 0, 0); push_exp(CG, 2, 0); push_exp(CB, 1, 1);
      batch_basic();
      wait_drain();
      toggle_mode = 1'b0;
      descend     = 1'b0;

      // Three batches streamed without gaps; the next batch's first image
      // must wait out the drain of the previous one.
      // Grey pixels: all R, equal keys stay in arrival order.
      push_exp(CR, 2, 0); push_exp(CR, 0, 0); push_exp(CR, 3, 0); push_exp(CR, 1, 1);
      // Mixed pixels: class by count, R/G and R/B ties, cross-product order.
      push_exp(CR, 2, 0); push_exp(CG, 1, 0); push_exp(CG, 0, 0); push_exp(CB, 3, 1);
      // Full-scale magnitudes.
      push_exp(CR, 3, 0); push_exp(CR, 1, 0); push_exp(CR, 0, 0); push_exp(CR, 2, 1);
      send_image(2, px(80, 80, 80), PIX, px(80, 80, 80));
      send_image(0, px(80, 80, 80), PIX, px(80, 80, 80));
      send_image(3, px(80, 80, 80), PIX, px(80, 80, 80));
      send_image(1, px(80, 80, 80), PIX, px(80, 80, 80));
      send_image(0, px(0, 100, 0), 9, px(200, 0, 0));
      send_image(1, px(0, 60, 0), PIX, px(0, 60, 0));
      send_image(2, px(30, 30, 0), 8, px(0, 0, 90));
      send_image(3, px(0, 0, 40), 10, px(0, 250, 0));
      send_image(0, px(255, 0, 0), PIX, px(255, 0, 0));
      send_image(1, px(254, 0, 0), PIX, px(254, 0, 0));
      send_image(2, px(255, 0, 0), PIX, px(255, 0, 0));
      send_image(3, px(1, 0, 0), PIX, px(1, 0, 0));
      wait_drain();

      // Reset while the second insertion is multiplying.
      send_image(0, px(10, 0, 0), PIX, px(10, 0, 0));
      send_image(1, px(20, 0, 0), PIX, px(20, 0, 0));
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      #1;
      reset_checks();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      push_exp(CR, 0, 0); push_exp(CR, 3, 0); push_exp(CG, 2, 0); push_exp(CB, 1, 1);
      batch_basic();
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
